// File: rtl/sum_window_accumulator.sv
// Adds BEAT_COUNT consecutive upstream sums into one window total and holds it on a
// registered valid/ready output. Define SUM_WIN_FLUSH_EN to add flush_i (early window close).
module sum_window_accumulator #(
    parameter int DATA_IN_WIDTH = 8,
    parameter int BEAT_COUNT    = 4,
    localparam int ACC_W        = DATA_IN_WIDTH + 1 + $clog2(BEAT_COUNT),
    localparam int CNT_W        = $clog2(BEAT_COUNT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_IN_WIDTH:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_valid,
`ifdef SUM_WIN_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   out_data_nxt;
    logic [CNT_W-1:0]   out_beats_nxt;
    logic               take;
    logic               flush;
    logic [ACC_W-1:0]   sum_eff;
    logic [CNT_W-1:0]   cnt_eff;

`ifdef SUM_WIN_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign take      = in_valid & in_ready;
    assign out_valid = (state == HOLD);

    // Window contents as they would stand after this cycle's beat, if any.
    assign sum_eff = acc + (take ? ACC_W'(in_data) : '0);
    assign cnt_eff = cnt + CNT_W'(take);

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        out_data_nxt  = out_data;
        out_beats_nxt = out_beats;
        case (state)
            ACCUM: begin
                if (take) begin
                    acc_nxt = sum_eff;
                    cnt_nxt = cnt_eff;
                end
                if ((cnt_eff == CNT_W'(BEAT_COUNT)) || (flush && (cnt_eff != '0))) begin
                    out_data_nxt  = sum_eff;
                    out_beats_nxt = cnt_eff;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // in_ready is its own flop so it reads 0 through the reset cycle even though
    // the reset state is ACCUM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_beats <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_data  <= out_data_nxt;
            out_beats <= out_beats_nxt;
            in_ready  <= (state_nxt == ACCUM);
        end
    end

endmodule
